// File: rtl/store_align_buffer_pkg.sv
// Shared load/store definitions: store type codes and strobe/lane widths
// used by the store buffer and its lane aligner.
package store_align_buffer_pkg;

  localparam int STRB_W = 4;
  localparam int LANES  = 4;

  localparam logic [3:0] STORE_SB  = 4'h1;
  localparam logic [3:0] STORE_SH  = 4'h2;
  localparam logic [3:0] STORE_SW  = 4'h3;
  localparam logic [3:0] STORE_SC  = 4'h4;
  localparam logic [3:0] STORE_SWL = 4'h5;
  localparam logic [3:0] STORE_SWR = 4'h6;

endpackage

// File: rtl/store_lane_align.sv
// Combinational little-endian store aligner: places register data in its
// word lanes and derives byte strobes from the low address bits.
module store_lane_align
  import store_align_buffer_pkg::*;
(
  input  logic [3:0]        st_type,
  input  logic [1:0]        addr_lo,
  input  logic [31:0]       data,
  output logic [31:0]       wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              misalign
);

  // Unknown types and illegal offsets flag misalign with no strobes
  always_comb begin
    wdata    = '0;
    wstrb    = '0;
    misalign = 1'b0;
    case (st_type)
      STORE_SB: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = {24'b0, data[7:0]} << {addr_lo, 3'b000};
      end
      STORE_SH: begin
        if (addr_lo[0]) begin
          misalign = 1'b1;
        end else if (addr_lo[1]) begin
          wstrb = 4'b1100;
          wdata = {data[15:0], 16'b0};
        end else begin
          wstrb = 4'b0011;
          wdata = {16'b0, data[15:0]};
        end
      end
      STORE_SW, STORE_SC: begin
        if (addr_lo != 2'd0) begin
          misalign = 1'b1;
        end else begin
          wstrb = 4'b1111;
          wdata = data;
        end
      end
      STORE_SWL: begin
        case (addr_lo)
          2'd0:    begin wstrb = 4'b0001; wdata = {24'b0, data[31:24]}; end
          2'd1:    begin wstrb = 4'b0011; wdata = {16'b0, data[31:16]}; end
          2'd2:    begin wstrb = 4'b0111; wdata = {8'b0, data[31:8]};   end
          default: begin wstrb = 4'b1111; wdata = data;                 end
        endcase
      end
      STORE_SWR: begin
        case (addr_lo)
          2'd0:    begin wstrb = 4'b1111; wdata = data;                 end
          2'd1:    begin wstrb = 4'b1110; wdata = {data[23:0], 8'b0};   end
          2'd2:    begin wstrb = 4'b1100; wdata = {data[15:0], 16'b0};  end
          default: begin wstrb = 4'b1000; wdata = {data[7:0], 24'b0};   end
        endcase
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_align_buffer.sv
// Store buffer between MEM and the data-side memory port: aligns stores,
// queues them in a FIFO with youngest-entry merging and a load-hazard probe.
module store_align_buffer
  import store_align_buffer_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 32,
  parameter bit MERGE_EN = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_type,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic [31:0]                in_wdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [31:0]                out_wdata,
  output logic [STRB_W-1:0]          out_wstrb,
  input  logic [ADDR_W-1:0]          ld_addr,
  output logic                       ld_hit,
  output logic                       err,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-3:0]  mem_addr [DEPTH];
  logic [31:0]        mem_data [DEPTH];
  logic [STRB_W-1:0]  mem_strb [DEPTH];
  logic [DEPTH-1:0]   mem_valid;
  logic [PTR_W-1:0]   head, tail, youngest;
  logic [CNT_W-1:0]   count_q;

  logic [31:0]        al_wdata;
  logic [STRB_W-1:0]  al_wstrb;
  logic               al_misalign;
  logic               accept, push_ok, do_merge, do_write, pop;

  store_lane_align u_align (
    .st_type  (in_type),
    .addr_lo  (in_addr[1:0]),
    .data     (in_wdata),
    .wdata    (al_wdata),
    .wstrb    (al_wstrb),
    .misalign (al_misalign)
  );

  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign count     = count_q;
  assign youngest  = tail - PTR_W'(1);

  assign accept  = in_valid & in_ready;
  assign push_ok = accept & ~al_misalign;
  assign pop     = out_valid & out_ready;

  // With two or more entries the youngest is never the head, so merging is safe alongside a pop
  assign do_merge = MERGE_EN && push_ok && (count_q >= CNT_W'(2)) &&
                    (mem_addr[youngest] == in_addr[ADDR_W-1:2]);
  assign do_write = push_ok & ~do_merge;

  assign out_addr  = out_valid ? {mem_addr[head], 2'b00} : '0;
  assign out_wdata = out_valid ? mem_data[head] : '0;
  assign out_wstrb = out_valid ? mem_strb[head] : '0;

  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_valid[i] && ((ld_addr >> 2) == ADDR_W'(mem_addr[i])))
        ld_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      count_q   <= '0;
      err       <= 1'b0;
      mem_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_addr[i] <= '0;
        mem_data[i] <= '0;
        mem_strb[i] <= '0;
      end
    end else begin
      err <= accept & al_misalign;
      if (do_write) begin
        mem_addr[tail]  <= in_addr[ADDR_W-1:2];
        mem_data[tail]  <= al_wdata;
        mem_strb[tail]  <= al_wstrb;
        mem_valid[tail] <= 1'b1;
        tail            <= tail + PTR_W'(1);
      end
      if (do_merge) begin
        mem_strb[youngest] <= mem_strb[youngest] | al_wstrb;
        for (int b = 0; b < LANES; b++) begin
          if (al_wstrb[b])
            mem_data[youngest][8*b +: 8] <= al_wdata[8*b +: 8];
        end
      end
      if (pop) begin
        mem_valid[head] <= 1'b0;
        head            <= head + PTR_W'(1);
      end
      if (do_write && !pop)
        count_q <= count_q + CNT_W'(1);
      else if (!do_write && pop)
        count_q <= count_q - CNT_W'(1);
    end
  end

endmodule

// File: doc/store_align_buffer.md
# store_align_buffer

Parametrised store buffer sitting between the MEM stage and the data-side memory interface. It aligns each store (SB/SH/SW/SC/SWL/SWR) to its word lane and derives byte strobes from the address itself, then queues the result in a DEPTH-entry FIFO. The FIFO drains through a valid/ready write port, with optional same-word merging and a load-hazard check port. It supersedes the purely combinational store data modifier, which relied on externally supplied byte-valid bits.

## Interface
- DEPTH, 4, FIFO entries; power of two, >= 2
- ADDR_W, 32, byte address width
- MERGE_EN, 1, 1 = merge a store into the youngest entry when word addresses match
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  store request
- in_ready  out  1  buffer can accept (= !full)
- in_type  in  4  store type code from shared LS defines (STORE_SB/SH/SW/SC/SWL/SWR)
- in_addr  in  ADDR_W  byte address
- in_wdata  in  32  unaligned register data
- out_valid  out  1  head entry valid (= !empty)
- out_ready  in  1  memory side accepts head
- out_addr  out  ADDR_W  word-aligned address (low 2 bits zero)
- out_wdata  out  32  aligned data, unused lanes zero
- out_wstrb  out  4  byte strobes
- ld_addr  in  ADDR_W  load address probed by MEM stage
- ld_hit  out  1  combinational: any valid entry has the same word address
- err  out  1  one-cycle pulse: misaligned or unknown store dropped
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Alignment, little-endian, a = in_addr[1:0], d = in_wdata:
  - SB: strb = 1<<a; d[7:0] placed in lane a.
  - SH: a=0 -> 0011, {16'b0, d[15:0]}; a=2 -> 1100, {d[15:0], 16'b0}.
  - SW/SC: 1111, d.
  - SWL: a=0 -> 0001, {24'b0, d[31:24]}; 1 -> 0011, {16'b0, d[31:16]}; 2 -> 0111, {8'b0, d[31:8]}; 3 -> 1111, d.
  - SWR: a=0 -> 1111, d; 1 -> 1110, {d[23:0], 8'b0}; 2 -> 1100, {d[15:0], 16'b0}; 3 -> 1000, {d[7:0], 24'b0}.
- Drop conditions: SH with a[0]=1, SW/SC with a!=0, and unknown type. The request is consumed, nothing is enqueued, and err pulses.
- Merge (MERGE_EN=1):
  - Conditions: accepted store, count>=2, and the youngest entry's word address equals the incoming word address.
  - Action: strb |= new strb; lanes with a new strobe bit take the new data.
  - count is unchanged. The head entry is never merged into, so an entry already presented on out is never modified.
- Otherwise an accepted store is written at the tail pointer; pointers wrap modulo DEPTH.
- Pop happens on out_valid & out_ready; the head advances.
- ld_hit compares ld_addr[ADDR_W-1:2] against every valid entry. It excludes the entry popping in the same cycle only if the pop completes (ld_hit stays asserted for that entry during the pop cycle; conservative).

## Timing
- Reset: count=0, pointers=0, out_valid=0, in_ready=1, out_addr/out_wdata/out_wstrb=0, err=0, ld_hit=0.
- Enqueue latency: a store accepted in cycle N is visible on out in N+1 when the buffer was empty. There is no bypass path.
- Simultaneous push and pop: count is unchanged and both take effect.
- Full: in_ready=0, so a push is impossible even while a pop occurs in the same cycle. in_ready is derived from registered count.
- Merge and pop in the same cycle are legal, because the merge target is never the head.
- out_* are held stable while out_valid & !out_ready.
- Reset asserted mid-operation clears all entries at the next edge; queued stores are lost by design.
- err is registered and asserts in the cycle after the dropped request.

## Structure
- Store type codes come from the shared LS define file. Add a STRB_W=4 constant and a lane-count constant there as well.
- Alignment is a natural sub-module, store_lane_align: combinational type/addr/data in, wdata/wstrb/misalign out. The FIFO, merge and hazard logic stay in the top module.

## Test plan
- Reset, then SB addr 0x1003 data 0x000000AB -> next cycle out_addr 0x1000, out_wdata 0xAB000000, out_wstrb 1000, count 1.
- SWL addr 0x2001 data 0x11223344 then SWR addr 0x2001 data 0x55667788 with out_ready=0 -> after the second store: first entry {0x00001122, 0011} and second entry {0x66778800, 1110}. No merge occurs (count 2) because the first entry is the head. A third store, SB 0x2000 data 0x99, merges into entry 2 -> entry 2 becomes {0x66778899, 1111}, count stays 2.
- Fill 4 SW entries with out_ready=0 -> in_ready=0, count 4; assert out_ready with in_valid held -> exactly one pop per cycle and in_ready returns next cycle; FIFO order is preserved across pointer wrap.
- SH addr 0x3001 -> err pulses one cycle later, count unchanged, nothing appears on out.
- With 0x4008 queued, ld_addr 0x400A -> ld_hit=1; ld_addr 0x400C -> ld_hit=0.
- rst_n low for one cycle with 3 entries queued -> count=0, out_valid=0, in_ready=1 next cycle.
